// File: rtl/counter.sv
// Loadable, enable-gated up-counter with a programmable terminal count.
// Counts 0..MAX_COUNT, wraps to 0 and raises a one-cycle overflow pulse in
// the same cycle the wrapped zero appears. Both outputs come straight from
// flops, so no input reaches an output without passing through a register.
module counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    // Largest value representable in WIDTH bits. It is held in 64 bits so
    // that wide counters do not overflow the limit check itself.
    localparam longint unsigned MAX_ALLOWED = (64'd1 << WIDTH) - 64'd1;

    // Reject a terminal count that cannot be represented in the counter.
    if (WIDTH < 1) begin : g_bad_width
        $error("counter: WIDTH must be at least 1");
    end
    if ((MAX_COUNT < 0) || (longint'(MAX_COUNT) > longint'(MAX_ALLOWED))) begin : g_bad_max
        $error("counter: MAX_COUNT does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);

    logic [WIDTH-1:0] count_r;
    logic             overflow_r;
    logic [WIDTH-1:0] count_next_s;
    logic             overflow_next_s;

    // Next-state selection: load beats counting; a count at or above the
    // terminal value (including an out-of-range load) wraps on the next
    // enabled edge, so the wrap is modulo MAX_COUNT+1 rather than 2**WIDTH.
    always_comb begin
        count_next_s    = count_r;
        overflow_next_s = 1'b0;
        if (load) begin
            count_next_s    = load_value;
            overflow_next_s = 1'b0;
        end else if (enable) begin
            if (count_r >= TERMINAL) begin
                count_next_s    = ZERO;
                overflow_next_s = 1'b1;
            end else begin
                count_next_s    = count_r + ONE;
                overflow_next_s = 1'b0;
            end
        end else begin
            count_next_s    = count_r;
            overflow_next_s = 1'b0;
        end
    end

    // State and output registers; reset clears both immediately and holds them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r    <= ZERO;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
        end
    end

    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a full-range 8-bit build and a build with
// terminal count 9 share the same stimulus; each is compared against a
// behavioural model after every clock edge, plus constant spot checks.
module tb_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] count_a;
    logic       overflow_a;
    logic [7:0] count_b;
    logic       overflow_b;

    int checks = 0;
    int errors = 0;

    // Model state for the two builds.
    int model_a;
    int model_b;
    bit movf_a;
    bit movf_b;

    counter #(.WIDTH(8), .MAX_COUNT(255)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count_a),
        .overflow   (overflow_a)
    );

    counter #(.WIDTH(8), .MAX_COUNT(9)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count_b),
        .overflow   (overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural rule: a load sets the value; an enabled edge advances in
    // the ring 0..max, with anything at or above max treated as terminal.
    task automatic model_step(inout int m, inout bit o, input int max,
                              input bit en, input bit ld, input int lv);
        if (ld) begin
            m = lv;
            o = 1'b0;
        end else if (en) begin
            o = (m >= max);
            m = o ? 0 : (m + 1) % (max + 1);
        end else begin
            o = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_cnt_a"}, count_a, 8'(model_a));
        check({tag, "_ovf_a"}, {7'd0, overflow_a}, {7'd0, movf_a});
        check({tag, "_cnt_b"}, count_b, 8'(model_b));
        check({tag, "_ovf_b"}, {7'd0, overflow_b}, {7'd0, movf_b});
    endtask

    // Apply inputs away from the edge, clock once, then compare #1 later.
    task automatic step(input string tag, input logic en, input logic ld, input logic [7:0] lv);
        enable     = en;
        load       = ld;
        load_value = lv;
        @(posedge clk);
        model_step(model_a, movf_a, 255, en, ld, int'(lv));
        model_step(model_b, movf_b, 9, en, ld, int'(lv));
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 8'h00;
        model_a = 0; model_b = 0; movf_a = 1'b0; movf_b = 1'b0;

        // 1. reset held for two edges, released with enable low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", count_a, 8'h00);
        check("rst_ovf", {7'd0, overflow_a}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 8'h00);
        check("idle_hold", count_a, 8'h00);

        // 2. five enabled edges from zero.
        for (int i = 0; i < 5; i++) step("cnt5", 1'b1, 1'b0, 8'h00);
        check("cnt5_val", count_a, 8'h05);
        check("cnt5_b", count_b, 8'h05);

        // 3. load with enable high wins; then resume counting.
        step("ldA5", 1'b1, 1'b1, 8'hA5);
        check("ldA5_val", count_a, 8'hA5);
        step("A6", 1'b1, 1'b0, 8'h00);
        check("A6_val", count_a, 8'hA6);
        check("A5_oor_b", count_b, 8'h00);
        check("A5_oor_bovf", {7'd0, overflow_b}, 8'h01);

        // 4. full-range wrap FE -> FF -> 00 (ovf) -> 01.
        step("ldFE", 1'b0, 1'b1, 8'hFE);
        step("FF", 1'b1, 1'b0, 8'h00);
        check("FF_val", count_a, 8'hFF);
        check("FF_ovf", {7'd0, overflow_a}, 8'h00);
        step("wrap", 1'b1, 1'b0, 8'h00);
        check("wrap_val", count_a, 8'h00);
        check("wrap_ovf", {7'd0, overflow_a}, 8'h01);
        step("post", 1'b1, 1'b0, 8'h00);
        check("post_val", count_a, 8'h01);
        check("post_ovf", {7'd0, overflow_a}, 8'h00);

        // 5. hold for four edges.
        for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 8'h00);
        check("hold_val", count_a, 8'h01);

        // Load at terminal with enable: load wins, overflow stays low.
        step("ldFF", 1'b1, 1'b1, 8'hFF);
        step("ldFF2", 1'b1, 1'b1, 8'hFF);
        check("ldwin_ovf", {7'd0, overflow_a}, 8'h00);

        // Terminal-9 build: 8 -> 9 -> 0 (ovf).
        step("ld8", 1'b0, 1'b1, 8'h08);
        step("b9", 1'b1, 1'b0, 8'h00);
        check("b9_val", count_b, 8'h09);
        step("b0", 1'b1, 1'b0, 8'h00);
        check("b0_val", count_b, 8'h00);
        check("b0_ovf", {7'd0, overflow_b}, 8'h01);

        // Out-of-range load 0C on the terminal-9 build wraps next edge.
        step("ld0C", 1'b0, 1'b1, 8'h0C);
        check("ld0C_val", count_b, 8'h0C);
        step("oor", 1'b1, 1'b0, 8'h00);
        check("oor_val", count_b, 8'h00);
        check("oor_ovf", {7'd0, overflow_b}, 8'h01);

        // 6. asynchronous reset between edges while count shows 37.
        step("ld37", 1'b0, 1'b1, 8'h37);
        check("ld37_val", count_a, 8'h37);
        enable = 1'b1;
        load   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_cnt", count_a, 8'h00);
        check("async_ovf", {7'd0, overflow_a}, 8'h00);
        model_a = 0; model_b = 0; movf_a = 1'b0; movf_b = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold", count_a, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Randomised traffic against the model, biased towards counting.
        for (int i = 0; i < 400; i++) begin
            logic       en_r;
            logic       ld_r;
            logic [7:0] lv_r;
            en_r = ($urandom_range(0, 9) < 8);
            ld_r = ($urandom_range(0, 19) == 0);
            lv_r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                                : 8'($urandom_range(0, 255));
            step("rand", en_r, ld_r, lv_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
